// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_pkg
// Description : Shared types and constants for the round-robin bus
//               interconnect: FSM state encoding, slave-select field width
//               and the all-zero data word.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Transaction phases of the interconnect
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_t;

  // Number of top address bits that select the slave
  localparam int SEL_W = 4;

  // Zero data word; cast to the data width at the point of use
  localparam logic [63:0] ZeroWord = 64'h0;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search starts at
//               ptr+1 (mod N) and returns the first active request as a
//               one-hot grant plus its binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int cand;

  // Rotating priority search beginning just after the last winner
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bus_rr_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_interconnect
// Description : N-master / M-slave single-transaction bus interconnect with
//               round-robin arbitration. The winner's request is latched,
//               decoded by the top SEL_W address bits, forwarded to one
//               slave, and the response is returned one cycle after the
//               slave acknowledges. Unmapped addresses complete with error.
// Options     : BUS_TIMEOUT_EN - when defined, a BUSY cycle counter ends a
//               transaction with error after TIMEOUT_CYCLES without ack.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_interconnect
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
  output logic [NUM_MASTERS-1:0]        m_gnt_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic                          m_err_o,
  output logic [DATA_W-1:0]             m_data_o,
  output logic [NUM_SLAVES-1:0]         s_req_o,
  output logic [NUM_SLAVES-1:0]         s_we_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_data_o,
  input  logic [NUM_SLAVES-1:0]         s_ack_i,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_data_i
);

  localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Pointer reset to the last master so that master 0 wins first
  localparam logic [MIDX_W-1:0] PTR_RST = MIDX_W'(NUM_MASTERS - 1);

  bus_state_t        state;
  bus_state_t        state_nx;

  logic [MIDX_W-1:0] ptr;
  logic [MIDX_W-1:0] owner;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_we;
  logic [SEL_W-1:0]  lat_sel;
  logic              lat_miss;

  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [MIDX_W-1:0]      arb_idx;
  logic                   arb_valid;

  logic [ADDR_W-1:0] win_addr;
  logic [SEL_W-1:0]  win_sel;
  logic              win_miss;

  logic [15:0]       ack_pad;
  logic              sel_ack;
  logic [DATA_W-1:0] rd_word;
  logic              timeout_hit;
  logic              finish_busy;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (MIDX_W)
  ) u_arb (
    .req   (m_req_i),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign win_addr = m_addr_i[arb_idx*ADDR_W +: ADDR_W];
  assign win_sel  = win_addr[ADDR_W-1 -: SEL_W];
  assign win_miss = (int'(win_sel) >= NUM_SLAVES);

  // Acknowledge and read data of the currently selected slave only
  always_comb begin
    ack_pad                 = '0;
    ack_pad[NUM_SLAVES-1:0] = s_ack_i;
    sel_ack                 = ~lat_miss & ack_pad[lat_sel];
    rd_word                 = DATA_W'(ZeroWord);
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (lat_sel == SEL_W'(j)) begin
        rd_word = s_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt;

  assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  // Count BUSY cycles spent waiting for the slave
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == ST_BUSY) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign finish_busy = lat_miss | sel_ack | timeout_hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and phase-decoded outputs
  always_comb begin
    state_nx = state;
    m_gnt_o  = '0;
    m_ack_o  = '0;
    s_req_o  = '0;
    s_we_o   = '0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        if (finish_busy) state_nx = ST_RESP;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          m_gnt_o[i] = (owner == MIDX_W'(i));
        end
        for (int j = 0; j < NUM_SLAVES; j++) begin
          s_req_o[j] = ~lat_miss & (lat_sel == SEL_W'(j));
          s_we_o[j]  = ~lat_miss & lat_we & (lat_sel == SEL_W'(j));
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          m_ack_o[i] = (owner == MIDX_W'(i));
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Capture the winning request and advance the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= PTR_RST;
      owner    <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= '0;
      lat_miss <= 1'b0;
    end else if (state == ST_IDLE && arb_valid) begin
      ptr      <= arb_idx;
      owner    <= arb_idx;
      lat_addr <= win_addr;
      lat_data <= m_data_i[arb_idx*DATA_W +: DATA_W];
      lat_we   <= m_we_i[arb_idx];
      lat_sel  <= win_sel;
      lat_miss <= win_miss;
    end
  end

  // Register the response; it is only non-zero during RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err  <= 1'b0;
      resp_data <= '0;
    end else if (state == ST_BUSY && finish_busy) begin
      resp_err  <= ~sel_ack;
      resp_data <= (~sel_ack | lat_we) ? DATA_W'(ZeroWord) : rd_word;
    end else if (state == ST_RESP) begin
      resp_err  <= 1'b0;
      resp_data <= '0;
    end
  end

  assign m_err_o  = resp_err;
  assign m_data_o = resp_data;
  assign s_addr_o = lat_addr;
  assign s_data_o = lat_data;

endmodule : bus_rr_interconnect
`default_nettype wire

// File: tb/tb_bus_rr_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_rr_interconnect
// Description : Self-checking bench for bus_rr_interconnect: directed
//               scenarios with literal expectations, then randomized
//               masters/slaves compared every cycle against a
//               transaction-level model.
// Options     : BUS_TIMEOUT_EN - enables the slave-timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rr_interconnect;

  localparam int NM = 3;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NM-1:0]    m_req  = '0;
  logic [NM-1:0]    m_we   = '0;
  logic [NM*AW-1:0] m_addr = '0;
  logic [NM*DW-1:0] m_data = '0;
  logic [NM-1:0]    m_gnt, m_ack;
  logic             m_err;
  logic [DW-1:0]    m_rdata;
  logic [NS-1:0]    s_req, s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS-1:0]    s_ack  = '0;
  logic [NS*DW-1:0] s_rdata = '0;

  int checks   = 0;
  int failures = 0;

  bus_rr_interconnect #(
    .NUM_MASTERS    (NM),
    .NUM_SLAVES     (NS),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req_i  (m_req),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_data_i (m_data),
    .m_gnt_o  (m_gnt),
    .m_ack_o  (m_ack),
    .m_err_o  (m_err),
    .m_data_o (m_rdata),
    .s_req_o  (s_req),
    .s_we_o   (s_we),
    .s_addr_o (s_addr),
    .s_data_o (s_wdata),
    .s_ack_i  (s_ack),
    .s_data_i (s_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus agents ----------------
  int  slv_mode  = 1;   // 0 random delay, 1 immediate ack, 2 never ack
  bit  rand_mode = 0;
  bit  fix_rd_en = 0;
  int  slv_cnt   = -1;

  task automatic drive_slaves();
    logic [NS-1:0] ack;
    for (int j = 0; j < NS; j++) s_rdata[j*DW +: DW] = $urandom;
    if (fix_rd_en) s_rdata[1*DW +: DW] = 32'hDEAD_BEEF;
    ack = '0;
    if (s_req == '0) begin
      slv_cnt = -1;
    end else begin
      if (slv_cnt < 0) slv_cnt = (slv_mode == 0) ? int'($urandom_range(0, 3)) : 0;
      if (slv_mode != 2) begin
        if (slv_cnt == 0) ack = s_req;
        else slv_cnt--;
      end
    end
    if (rand_mode) ack = ack | (NS'($urandom) & ~s_req);
    s_ack = ack;
  endtask

  task automatic drive_masters();
    for (int i = 0; i < NM; i++) begin
      if (m_ack[i]) m_req[i] = 1'b0;
      else if (!m_req[i] && ($urandom_range(0, 3) == 0)) m_req[i] = 1'b1;
      else if (m_req[i] && m_gnt[i] && ($urandom_range(0, 31) == 0)) m_req[i] = 1'b0;
      m_addr[i*AW +: AW] = {4'($urandom_range(0, 2)), 28'($urandom)};
      m_data[i*DW +: DW] = $urandom;
      m_we[i]            = 1'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) drive_masters();
    drive_slaves();
  endtask

  bit mdl_on = 0;

  task automatic do_reset();
    rst   = 1'b1;
    m_req = '0;
    tick();
    mdl_on = 1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- transaction-level reference model ----------------
  // phase: 0 waiting for requests, 1 transaction at a slave, 2 response
  int            md_phase = 0;
  int            md_owner = 0;
  int            md_last  = NM - 1;
  int            md_slv   = 0;
  bit            md_miss  = 0;
  bit            md_we    = 0;
  logic [AW-1:0] md_addr  = '0;
  logic [DW-1:0] md_wdata = '0;
  bit            md_err   = 0;
  logic [DW-1:0] md_rdata = '0;
  int            md_wait  = 0;

  logic [NM-1:0] e_gnt, e_ack;
  logic [NS-1:0] e_sreq, e_swe;

  always @(negedge clk) begin
    if (mdl_on) begin
      e_gnt  = (md_phase == 1) ? NM'(1 << md_owner) : '0;
      e_ack  = (md_phase == 2) ? NM'(1 << md_owner) : '0;
      e_sreq = (md_phase == 1 && !md_miss) ? NS'(1 << md_slv) : '0;
      e_swe  = md_we ? e_sreq : '0;
      check("m_gnt", m_gnt, e_gnt);
      check("m_ack", m_ack, e_ack);
      check("s_req", s_req, e_sreq);
      check("s_we", s_we, e_swe);
      check("m_err", m_err, (md_phase == 2) ? md_err : 1'b0);
      check("m_data", m_rdata, (md_phase == 2) ? md_rdata : '0);
      check("s_addr", s_addr, md_addr);
      check("s_data", s_wdata, md_wdata);

      if (rst) begin
        md_phase = 0; md_last = NM - 1; md_owner = 0;
        md_addr = '0; md_wdata = '0; md_we = 0; md_miss = 0; md_slv = 0;
      end else if (md_phase == 0) begin
        for (int k = 1; k <= NM; k++) begin
          if (md_phase == 0 && m_req[(md_last + k) % NM]) begin
            md_owner = (md_last + k) % NM;
            md_phase = 1;
          end
        end
        if (md_phase == 1) begin
          md_last  = md_owner;
          md_addr  = m_addr[md_owner*AW +: AW];
          md_wdata = m_data[md_owner*DW +: DW];
          md_we    = m_we[md_owner];
          md_slv   = int'(md_addr[AW-1:AW-4]);
          md_miss  = (md_slv >= NS);
          md_wait  = 0;
        end
      end else if (md_phase == 1) begin
        if (md_miss) begin
          md_phase = 2; md_err = 1; md_rdata = '0;
        end else if (s_ack[md_slv]) begin
          md_phase = 2; md_err = 0;
          md_rdata = md_we ? '0 : s_rdata[md_slv*DW +: DW];
        end else begin
          md_wait++;
`ifdef BUS_TIMEOUT_EN
          if (md_wait == TO) begin
            md_phase = 2; md_err = 1; md_rdata = '0;
          end
`endif
        end
      end else begin
        md_phase = 0;
      end
    end
  end

  // ---------------- directed scenarios, then random traffic ----------------
  logic [NM-1:0] gseq [3];
  logic [NM-1:0] prev;
  int            gcount;

  initial begin
    // Both masters to slave 0, immediate ack: grants 0, 1, 0
    do_reset();
    check("reset_gnt", m_gnt, '0);
    check("reset_sreq", s_req, '0);
    slv_mode = 1;
    m_req = 3'b011;
    tick();
    check("first_grant_latency", m_gnt, 3'b001);
    check("first_sreq", s_req, 2'b01);
    tick();
    check("first_ack_latency", m_ack, 3'b001);
    gseq[0] = m_gnt_hist_first();
    gseq[1] = '0;
    gseq[2] = '0;
    gcount  = 1;
    prev    = m_gnt;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_gnt != '0 && prev == '0 && gcount < 3) begin
        gseq[gcount] = m_gnt;
        gcount++;
      end
      prev = m_gnt;
    end
    check("rr_grant_2", gseq[1], 3'b010);
    check("rr_grant_3", gseq[2], 3'b001);

    // Master 1 read from slave 1 returns DEADBEEF
    m_req = '0;
    do_reset();
    fix_rd_en = 1;
    m_addr[1*AW +: AW] = 32'h1000_0004;
    m_we[1] = 1'b0;
    m_req = 3'b010;
    tick();
    check("rd_gnt", m_gnt, 3'b010);
    check("rd_sreq", s_req, 2'b10);
    check("rd_saddr", s_addr, 32'h1000_0004);
    tick();
    check("rd_ack", m_ack, 3'b010);
    check("rd_data", m_rdata, 32'hDEAD_BEEF);
    check("rd_err", m_err, 1'b0);
    m_req = '0;
    tick();
    check("rd_ack_pulse", m_ack, 3'b000);
    fix_rd_en = 0;

    // Write to unmapped slave 15: decode miss
    do_reset();
    m_addr[0*AW +: AW] = 32'hF000_0000;
    m_data[0*DW +: DW] = 32'h1234_5678;
    m_we[0] = 1'b1;
    m_req = 3'b001;
    tick();
    check("miss_gnt", m_gnt, 3'b001);
    check("miss_sreq", s_req, 2'b00);
    tick();
    check("miss_ack", m_ack, 3'b001);
    check("miss_err", m_err, 1'b1);
    check("miss_data", m_rdata, 32'h0);
    m_req = '0;
    tick();
    check("miss_ack_pulse", m_ack, 3'b000);

    // Reset during BUSY cycle 3 aborts; next grant goes to master 0
    do_reset();
    slv_mode = 2;
    m_addr[0*AW +: AW] = 32'h0000_0010;
    m_addr[1*AW +: AW] = 32'h0000_0020;
    m_we = '0;
    m_req = 3'b001;
    tick();
    tick();
    tick();
    check("abort_busy3_gnt", m_gnt, 3'b001);
    rst = 1'b1;
    tick();
    check("abort_gnt", m_gnt, '0);
    check("abort_ack", m_ack, '0);
    check("abort_sreq", s_req, '0);
    check("abort_err", m_err, 1'b0);
    check("abort_saddr", s_addr, '0);
    rst = 1'b0;
    slv_mode = 1;
    m_req = 3'b011;
    tick();
    check("abort_next_gnt", m_gnt, 3'b001);
    m_req = '0;
    tick();
    tick();

`ifdef BUS_TIMEOUT_EN
    // Slave never acks: error after TO BUSY cycles
    do_reset();
    slv_mode = 2;
    m_addr[0*AW +: AW] = 32'h1000_0000;
    m_we[0] = 1'b0;
    m_req = 3'b001;
    for (int c = 0; c < TO; c++) tick();
    check("to_last_busy_gnt", m_gnt, 3'b001);
    check("to_last_busy_sreq", s_req, 2'b10);
    tick();
    check("to_ack", m_ack, 3'b001);
    check("to_err", m_err, 1'b1);
    check("to_data", m_rdata, 32'h0);
    check("to_sreq", s_req, 2'b00);
    m_req = '0;
    tick();
`endif

    // Randomized traffic against the model
    do_reset();
    slv_mode  = 0;
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) tick();
    rand_mode = 0;
    m_req = '0;
    s_ack = '0;
    slv_mode = 1;
    for (int c = 0; c < 10; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [NM-1:0] m_gnt_hist_first();
    // The first grant of the round-robin sequence was already checked to be
    // master 0; record the literal so the sequence table is complete.
    return 3'b001;
  endfunction

endmodule : tb_bus_rr_interconnect
`default_nettype wire
